// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and event-codes one raw push-button.
// Produces a debounced level, a one-cycle press/repeat strobe, a one-cycle
// release strobe and a "held" flag while auto-repeat is running.
module btn_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 5_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release,
    output logic held
);

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    // Raw pad level that corresponds to "not pressed".
    localparam logic RAW_IDLE = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic               level_q, level_d;
    logic               pulse_q, pulse_d;
    logic               release_q, release_d;
    logic               held_q, held_d;
    logic               btn_sync;

    // Synchronizer shift: new raw sample enters at bit 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    assign btn_sync = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // Next-state, counter and registered-output logic for the debounce/repeat FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_sync) state_d = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = DB_RELEASE;
                end else if (!repeat_en) begin
                    cnt_d = '0;
                end else if (cnt_q == RD_LAST) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!btn_sync) begin
                    state_d = DB_RELEASE;
                end else if (!repeat_en) begin
                    state_d = PRESSED;
                end else if (cnt_q == RR_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_RELEASE: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state change restarts the shared counter.
        if (state_d != state_q) cnt_d = '0;

        // Level stays asserted through release debounce until the release is accepted.
        level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == DB_RELEASE);
        held_d  = (state_d == REPEAT);
    end

    // State, counter, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sync_q    <= {SYNC_STAGES{RAW_IDLE}};
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;
    assign held        = held_q;

endmodule
